// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants for the bit-serial adder.
//   - State encoding constants S_IDLE/S_RUN/S_DONE and the typed state enum.
//   - DEFAULT_WIDTH: default operand/sum width.
package serial_adder_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StRun  = S_RUN,
        StDone = S_DONE
    } state_e;

endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit full-adder cell.
// Ports:
//   a, b  - operand bits
//   c     - carry in
//   s     - sum bit
//   co    - carry out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock, LSB first, using a single
// fulladder cell. Start/done handshake; {cout,sum} = a + b + cin.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request an add (sampled only in IDLE)
//   a, b  - operands, captured on the accepted start
//   cin   - carry-in, captured on the accepted start
//   busy  - high while the add is in progress
//   done  - one-cycle pulse when sum/cout are valid
//   sum   - result, held until the next completed add
//   cout  - final carry-out, held with sum
//   ovf   - signed overflow (SERIAL_ADDER_OVF_EN only)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_a_q;
    logic [WIDTH-1:0] shreg_b_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             c_msb_q;
    logic             ovf_q;
`endif

    logic fa_s;
    logic fa_co;

    fulladder u_fa (
        .a  (shreg_a_q[0]),
        .b  (shreg_b_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_a_q <= '0;
            shreg_b_q <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            c_msb_q   <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        shreg_a_q <= a;
                        shreg_b_q <= b;
                        carry_q   <= cin;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    sum_sh_q  <= {fa_s, sum_sh_q[WIDTH-1:1]};
                    carry_q   <= fa_co;
                    shreg_a_q <= shreg_a_q >> 1;
                    shreg_b_q <= shreg_b_q >> 1;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastBit) begin
                        busy_q  <= 1'b0;
                        state_q <= StDone;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q here is the carry into the MSB slice
                        c_msb_q <= carry_q;
`endif
                    end
                end
                StDone: begin
                    sum_q   <= sum_sh_q;
                    cout_q  <= carry_q;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_q   <= c_msb_q ^ carry_q;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
